// File: rtl/conv_pkg.sv
// Shared definitions for the K=3 rate-1/2 convolutional code (G0=111, G1=101).
// Encoder and decoder stages use the same generator taps and FSM state encoding.
package conv_pkg;

    localparam int K = 3;
    localparam logic [K-1:0] G0 = 3'b111;
    localparam logic [K-1:0] G1 = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ENC   = 2'b01,
        FLUSH = 2'b10,
        DONE  = 2'b11
    } conv_state_e;

    // Window is {u, s1, s0}; the coded bit is the parity of the tapped positions.
    function automatic logic gen_bit(input logic [K-1:0] g, input logic [K-1:0] win);
        return ^(g & win);
    endfunction

endpackage

// File: rtl/conv_enc_core.sv
// Combinational K=3 encoder step: coded pair from (u, s1, s0), mapped to BPSK symbols.
module conv_enc_core
    import conv_pkg::*;
#(
    parameter int AMP = 16
) (
    input  logic              u,
    input  logic              s1,
    input  logic              s0,
    output logic signed [7:0] sym_a,
    output logic signed [7:0] sym_b
);

    localparam logic signed [7:0] SYM_POS = 8'(AMP);
    localparam logic signed [7:0] SYM_NEG = -SYM_POS;

    logic c0_s;
    logic c1_s;

    // Coded bit 0 maps to +AMP, coded bit 1 to -AMP.
    always_comb begin
        c0_s  = gen_bit(G0, {u, s1, s0});
        c1_s  = gen_bit(G1, {u, s1, s0});
        sym_a = c0_s ? SYM_NEG : SYM_POS;
        sym_b = c1_s ? SYM_NEG : SYM_POS;
    end

endmodule

// File: rtl/conv_encoder_tx.sv
// Frame-based convolutional encoder transmitter: one message word in, MSG_BITS+2
// symbol pairs out (two zero tail bits terminate the trellis), then a done pulse.
module conv_encoder_tx
    import conv_pkg::*;
#(
    parameter int MSG_BITS = 4,
    parameter int AMP      = 16
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [MSG_BITS-1:0] msg_in,
    input  logic                in_valid,
    output logic                in_ready,
    output logic signed [7:0]   sym_a,
    output logic signed [7:0]   sym_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                done
);

    localparam int CW = $clog2(MSG_BITS + 2);
    localparam logic [CW-1:0] LAST_MSG  = CW'(MSG_BITS - 1);
    localparam logic [CW-1:0] LAST_TAIL = CW'(MSG_BITS + 1);

    conv_state_e         state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [MSG_BITS-1:0] msg_q, msg_d;
    logic                s1_q, s1_d, s0_q, s0_d;
    logic signed [7:0]   sym_a_q, sym_a_d, sym_b_q, sym_b_d;
    logic                out_valid_q, out_valid_d;
    logic                in_ready_q, in_ready_d;
    logic                done_q, done_d;

    logic                load_s, u_s, base_s1_s, base_s0_s;
    logic signed [7:0]   core_a_s, core_b_s;

    conv_enc_core #(.AMP(AMP)) u_core (
        .u     (u_s),
        .s1    (base_s1_s),
        .s0    (base_s0_s),
        .sym_a (core_a_s),
        .sym_b (core_b_s)
    );

    // Next-state logic; cnt_q is the index of the pair currently presented.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        msg_d       = msg_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        done_d      = 1'b0;
        load_s      = 1'b0;
        u_s         = 1'b0;
        base_s1_s   = s1_q;
        base_s0_s   = s0_q;
        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid) begin
                    load_s      = 1'b1;
                    u_s         = msg_in[MSG_BITS-1];
                    base_s1_s   = 1'b0;
                    base_s0_s   = 1'b0;
                    msg_d       = {msg_in[MSG_BITS-2:0], 1'b0};
                    cnt_d       = '0;
                    state_d     = ENC;
                    in_ready_d  = 1'b0;
                    out_valid_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            ENC: begin
                if (out_valid_q && out_ready) begin
                    load_s = 1'b1;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == LAST_MSG) begin
                        u_s     = 1'b0;
                        state_d = FLUSH;
                    end else begin
                        u_s   = msg_q[MSG_BITS-1];
                        msg_d = {msg_q[MSG_BITS-2:0], 1'b0};
                    end
                end else begin
                    state_d = ENC;
                end
            end
            FLUSH: begin
                if (out_valid_q && out_ready) begin
                    if (cnt_q == LAST_TAIL) begin
                        state_d     = DONE;
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        load_s = 1'b1;
                        u_s    = 1'b0;
                        cnt_d  = cnt_q + CW'(1);
                    end
                end else begin
                    state_d = FLUSH;
                end
            end
            DONE: begin
                state_d    = IDLE;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
            end
        endcase

        if (load_s) begin
            sym_a_d = core_a_s;
            sym_b_d = core_b_s;
            s1_d    = u_s;
            s0_d    = base_s1_s;
        end else begin
            sym_a_d = sym_a_q;
            sym_b_d = sym_b_q;
            s1_d    = s1_q;
            s0_d    = s0_q;
        end
    end

    // State, datapath and registered outputs.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            msg_q       <= '0;
            s1_q        <= 1'b0;
            s0_q        <= 1'b0;
            sym_a_q     <= 8'sd0;
            sym_b_q     <= 8'sd0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            msg_q       <= msg_d;
            s1_q        <= s1_d;
            s0_q        <= s0_d;
            sym_a_q     <= sym_a_d;
            sym_b_q     <= sym_b_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            done_q      <= done_d;
        end
    end

    assign sym_a     = sym_a_q;
    assign sym_b     = sym_b_q;
    assign out_valid = out_valid_q;
    assign in_ready  = in_ready_q;
    assign done      = done_q;

endmodule

// File: tb/tb_conv_encoder_tx.sv
// Self-checking bench for conv_encoder_tx: directed frames, backpressure, mid-frame
// reset and randomized frames, compared against a sequence-level convolution model.
module tb_conv_encoder_tx;

    localparam int MB  = 4;
    localparam int AMP = 16;
    localparam int NP  = MB + 2;

    logic                 CLK = 1'b0;
    logic                 RST_N;
    logic [MB-1:0]        msg_in;
    logic                 in_valid, in_ready, out_valid, out_ready, done;
    logic signed [7:0]    sym_a, sym_b;

    logic [MB-1:0]        msg2;
    logic                 iv2, ir2, ov2, or2, done2;
    logic signed [7:0]    sa2, sb2;

    int checks   = 0;
    int failures = 0;
    int exp_a [NP];
    int exp_b [NP];

    always #5 CLK = ~CLK;

    conv_encoder_tx #(.MSG_BITS(MB), .AMP(AMP)) dut (
        .CLK(CLK), .RST_N(RST_N), .msg_in(msg_in), .in_valid(in_valid),
        .in_ready(in_ready), .sym_a(sym_a), .sym_b(sym_b), .out_valid(out_valid),
        .out_ready(out_ready), .done(done)
    );

    conv_encoder_tx #(.MSG_BITS(MB), .AMP(127)) dut127 (
        .CLK(CLK), .RST_N(RST_N), .msg_in(msg2), .in_valid(iv2),
        .in_ready(ir2), .sym_a(sa2), .sym_b(sb2), .out_valid(ov2),
        .out_ready(or2), .done(done2)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: bit sequence = message MSB first then two zeros, preceded by two zeros;
    // c0 = u[k]^u[k-1]^u[k-2], c1 = u[k]^u[k-2].
    function automatic void ref_pairs(input logic [MB-1:0] m, input int amp);
        int u [NP+2];
        int c0, c1;
        u[0] = 0;
        u[1] = 0;
        for (int k = 0; k < NP; k++)
            u[k+2] = (k < MB) ? int'(m[MB-1-k]) : 0;
        for (int k = 0; k < NP; k++) begin
            c0 = u[k+2] ^ u[k+1] ^ u[k];
            c1 = u[k+2] ^ u[k];
            exp_a[k] = c0 ? -amp : amp;
            exp_b[k] = c1 ? -amp : amp;
        end
    endfunction

    // Called at a negedge with the DUT idle; returns at the negedge after done.
    // mode 0: always ready, 1: random ready, 2: three stall cycles on the second pair.
    task automatic run_frame(input logic [MB-1:0] m, input int mode);
        int k = 0;
        int cyc = 0;
        int stall = 0;
        ref_pairs(m, AMP);
        chk("idle_in_ready", int'(in_ready), 1);
        chk("idle_out_valid", int'(out_valid), 0);
        msg_in   = m;
        in_valid = 1'b1;
        @(negedge CLK);
        while (k < NP && cyc < 200) begin
            chk("busy_in_ready", int'(in_ready), 0);
            chk("busy_out_valid", int'(out_valid), 1);
            chk("busy_done", int'(done), 0);
            chk($sformatf("sym_a[%0d]", k), int'(sym_a), exp_a[k]);
            chk($sformatf("sym_b[%0d]", k), int'(sym_b), exp_b[k]);
            in_valid = 1'($urandom_range(0, 1));
            msg_in   = MB'($urandom);
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (k == 1 && stall < 3) begin
                        out_ready = 1'b0;
                        stall++;
                    end else begin
                        out_ready = 1'b1;
                    end
                end
            endcase
            if (out_ready) k++;
            cyc++;
            @(negedge CLK);
        end
        chk("frame_bound", k, NP);
        chk("done_pulse", int'(done), 1);
        chk("done_out_valid", int'(out_valid), 0);
        chk("done_in_ready", int'(in_ready), 0);
        if (mode != 1) chk("frame_cycles", cyc, (mode == 0) ? NP : NP + 3);
        in_valid  = 1'($urandom_range(0, 1));
        msg_in    = MB'($urandom);
        out_ready = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("done_clear", int'(done), 0);
        chk("back_idle", int'(in_ready), 1);
    endtask

    initial begin
        RST_N = 1'b0; in_valid = 1'b0; out_ready = 1'b0; msg_in = '0;
        iv2 = 1'b0; or2 = 1'b0; msg2 = '0;
        #12;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_sym_a", int'(sym_a), 0);
        chk("rst_sym_b", int'(sym_b), 0);
        @(negedge CLK);
        RST_N = 1'b1;

        run_frame(4'b1011, 0);
        run_frame(4'b0000, 0);
        run_frame(4'b1011, 2);

        // Reset after the third pair is accepted, then a clean frame.
        ref_pairs(4'b1011, AMP);
        msg_in = 4'b1011; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge CLK);
        in_valid = 1'b0;
        repeat (3) @(negedge CLK);
        chk("pre_rst_sym_a", int'(sym_a), exp_a[3]);
        chk("pre_rst_valid", int'(out_valid), 1);
        #2 RST_N = 1'b0;
        #1;
        chk("async_out_valid", int'(out_valid), 0);
        chk("async_sym_a", int'(sym_a), 0);
        chk("async_in_ready", int'(in_ready), 1);
        chk("async_done", int'(done), 0);
        @(negedge CLK);
        RST_N = 1'b1;
        run_frame(4'b1011, 0);

        for (int i = 0; i < 20; i++)
            run_frame(MB'($urandom), int'($urandom_range(0, 2)));

        // Large amplitude instance.
        ref_pairs(4'b1111, 127);
        msg2 = 4'b1111; iv2 = 1'b1; or2 = 1'b1;
        @(negedge CLK);
        iv2 = 1'b0;
        for (int k = 0; k < NP; k++) begin
            chk($sformatf("a127_valid[%0d]", k), int'(ov2), 1);
            chk($sformatf("a127_sym_a[%0d]", k), int'(sa2), exp_a[k]);
            chk($sformatf("a127_sym_b[%0d]", k), int'(sb2), exp_b[k]);
            @(negedge CLK);
        end
        chk("a127_done", int'(done2), 1);
        chk("a127_in_ready", int'(ir2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/conv_encoder_tx.md
CONV_ENCODER_TX -- requirements
Module: conv_encoder_tx

Interface
REQ-001 SHALL have parameter MSG_BITS, default 4, message bits per frame (legal range 2..16).
REQ-002 SHALL have parameter AMP, default 16, BPSK symbol magnitude (legal range 1..127).
REQ-003 SHALL have port CLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port msg_in, input, MSG_BITS bits: message word, transmitted MSB first.
REQ-006 SHALL have port in_valid, input, 1 bit: msg_in is valid.
REQ-007 SHALL have port in_ready, output, 1 bit: block can accept a message.
REQ-008 SHALL have port sym_a, output, 8 bits, signed: symbol for generator G0 = 111.
REQ-009 SHALL have port sym_b, output, 8 bits, signed: symbol for generator G1 = 101.
REQ-010 SHALL have port out_valid, output, 1 bit: sym_a/sym_b hold a valid pair.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream (decoder side) accepts the pair.
REQ-012 SHALL have port done, output, 1 bit: one-cycle pulse after the final tail pair is accepted.

Function
REQ-013 SHALL implement a rate-1/2, K=3 convolutional encoder; shift register {s1,s0} (s1 = most recent bit) cleared to 00 at frame start.
REQ-014 For input bit u, SHALL compute c0 = u^s1^s0 and c1 = u^s0, then update s1<=u, s0<=s1.
REQ-015 SHALL map coded bit 0 to +AMP and coded bit 1 to -AMP (8-bit two's complement); sym_a carries c0, sym_b carries c1.
REQ-016 SHALL use FSM states IDLE, ENC, FLUSH, DONE.
REQ-017 In IDLE, in_ready=1 and out_valid=0; the edge with in_valid&&in_ready captures msg_in, clears {s1,s0}, registers the pair for the message MSB, and moves to ENC (out_valid=1 on the next cycle, latency 1).
REQ-018 In ENC/FLUSH, a pair is accepted on an edge with out_valid&&out_ready; the same edge registers the next pair, so back-to-back acceptance gives one pair per cycle.
REQ-019 While out_valid=1 and out_ready=0, sym_a, sym_b and out_valid SHALL hold stable.
REQ-020 After the MSG_BITS-th message pair is accepted, SHALL enter FLUSH and emit exactly 2 tail pairs with u=0, terminating the trellis in state 00.
REQ-021 When the second tail pair is accepted, SHALL enter DONE with out_valid=0; done=1 for exactly that one cycle; next edge returns to IDLE.
REQ-022 in_ready SHALL be 0 in ENC, FLUSH and DONE; in_valid in those states SHALL be ignored (no capture, no error).
REQ-023 Frame length SHALL be exactly MSG_BITS+2 accepted pairs; a bit counter SHALL count 0..MSG_BITS+1 without wrap beyond that range.

Reset
REQ-024 RST_N=0 SHALL asynchronously force IDLE, {s1,s0}=00, counter=0, sym_a=0, sym_b=0, out_valid=0, done=0, in_ready=1.
REQ-025 Reset asserted mid-frame SHALL abandon the frame with no further pairs and no done pulse; the first edge after release behaves as IDLE.

Structure
REQ-026 Package conv_pkg SHALL hold K=3, G0=3'b111, G1=3'b101, and the FSM state enumeration, so the decoder stages share the same generator definitions.
REQ-027 A single combinational sub-module conv_enc_core SHALL compute {c0,c1} from (u,s1,s0) and map them to signed symbols; conv_encoder_tx holds the FSM, counter, message shift register and output registers.

Verification
REQ-028 msg_in=4'b1011, out_ready held 1 -> six pairs (-16,-16), (-16,+16), (+16,+16), (+16,-16), (+16,-16), (-16,-16) on consecutive cycles, then done=1 for one cycle.
REQ-029 msg_in=4'b0000 -> six pairs (+16,+16); final state 00.
REQ-030 Same as REQ-028 but with out_ready=0 for 3 cycles while the second pair is presented -> (-16,+16) held stable; sequence otherwise unchanged; done is 3 cycles later.
REQ-031 Assert RST_N=0 after the third pair is accepted -> out_valid=0 immediately (asynchronous); a new frame 4'b1011 afterwards reproduces the REQ-028 sequence exactly.
REQ-032 in_valid held 1 with a second message during the frame -> in_ready=0 and the message is ignored until IDLE; then it is captured the cycle after done.
REQ-033 AMP=127, msg 4'b1111 -> symbols limited to +127/-127; pair 1 is (-127,-127).
